// File: rtl/calc_core_seq.sv
// Sequential signed calculator: debounced enter starts add/sub/mul/div on W-bit operands,
// then converts the result magnitude to BCD. All outputs are registered and held between operations.
module calc_core_seq #(
    parameter int W        = 4,
    parameter int DIGITS   = 3,
    parameter int DEBOUNCE = 16
) (
    input  logic                  clk,
    input  logic                  ar,
    input  logic                  enter,
    input  logic [1:0]            select,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  sign,
    output logic                  signA,
    output logic                  signB,
    output logic [W-1:0]          a_mag,
    output logic [W-1:0]          b_mag,
    output logic [2*W-1:0]        f_out,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [2:0]            state_dbg
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int IW = $clog2(2 * W);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
        S_CONV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                state;
    logic                  sync1, sync2;
    logic [CW-1:0]         cnt;
    logic                  start;
    logic [1:0]            op;
    logic [W-1:0]          a_s, b_s;
    logic [IW-1:0]         iter;
    logic [2*W-1:0]        acc, mcand;
    logic [W-1:0]          mplier;
    logic [W-1:0]          rem;
    logic [2*W-1:0]        res;
    logic                  res_sign;
    logic [2*W-1:0]        bin;
    logic [4*DIGITS-1:0]   bcd_sh;

    logic [W:0]            addsub, as_mag;
    logic [2*W-1:0]        mul_acc_nx;
    logic [W:0]            rem_sh, rem_diff;
    logic                  div_ge;
    logic [W-1:0]          rem_nx, quo_nx;
    logic [2*W-1:0]        exec_res;
    logic                  exec_neg, exec_last;
    logic [4*DIGITS-1:0]   bcd_adj, bcd_nx;

    function automatic logic [W-1:0] mag(input logic [W-1:0] x);
        return x[W-1] ? (~x + 1'b1) : x;
    endfunction

    // Handshake: start is a one-cycle request accepted only in IDLE (dropped otherwise);
    // done is a one-cycle pulse qualifying f_out/sign/err/bcd, which then hold until the next done.
    assign start     = sync2 && (cnt == CW'(DEBOUNCE - 1));
    assign state_dbg = state;

    always_comb begin
        addsub     = (op == OP_SUB) ? ({a_s[W-1], a_s} - {b_s[W-1], b_s})
                                    : ({a_s[W-1], a_s} + {b_s[W-1], b_s});
        as_mag     = addsub[W] ? (~addsub + 1'b1) : addsub;
        mul_acc_nx = mplier[0] ? (acc + mcand) : acc;
        // Restoring step: borrow out of the trial subtraction means the divisor did not fit.
        rem_sh     = {rem, mplier[W-1]};
        rem_diff   = rem_sh - {1'b0, b_mag};
        div_ge     = ~rem_diff[W];
        rem_nx     = div_ge ? rem_diff[W-1:0] : rem_sh[W-1:0];
        quo_nx     = {mplier[W-2:0], div_ge};
        case (op)
            OP_MUL:  exec_res = mul_acc_nx;
            OP_DIV:  exec_res = {{W{1'b0}}, quo_nx};
            default: exec_res = {{(W-1){1'b0}}, as_mag};
        endcase
        exec_neg  = op[1] ? (signA ^ signB) : addsub[W];
        exec_last = !op[1] || (iter == IW'(W - 1));
        bcd_adj   = bcd_sh;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_sh[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] + 4'd3;
        end
        bcd_nx = {bcd_adj[4*DIGITS-2:0], bin[2*W-1]};
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state    <= S_IDLE;
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            sign     <= 1'b0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            a_mag    <= '0;
            b_mag    <= '0;
            f_out    <= '0;
            bcd      <= '0;
            op       <= OP_ADD;
            a_s      <= '0;
            b_s      <= '0;
            iter     <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            res      <= '0;
            res_sign <= 1'b0;
            bin      <= '0;
            bcd_sh   <= '0;
        end else begin
            sync1 <= enter;
            sync2 <= sync1;
            if (!sync2)
                cnt <= '0;
            else if (cnt != CW'(DEBOUNCE))
                cnt <= cnt + 1'b1;

            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    op     <= select;
                    a_s    <= a;
                    b_s    <= b;
                    signA  <= a[W-1];
                    signB  <= b[W-1];
                    a_mag  <= mag(a);
                    b_mag  <= mag(b);
                    iter   <= '0;
                    acc    <= '0;
                    rem    <= '0;
                    mcand  <= {{W{1'b0}}, mag(a)};
                    // Division shifts the dividend out of mplier while the quotient shifts in.
                    mplier <= (select == OP_DIV) ? mag(a) : mag(b);
                    if (select == OP_DIV && b == '0) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        sign  <= 1'b0;
                        f_out <= '0;
                        bcd   <= '0;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op == OP_MUL) begin
                        acc    <= mul_acc_nx;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end else if (op == OP_DIV) begin
                        rem    <= rem_nx;
                        mplier <= quo_nx;
                    end
                    if (exec_last) begin
                        res      <= exec_res;
                        bin      <= exec_res;
                        res_sign <= exec_neg && (exec_res != '0);
                        bcd_sh   <= '0;
                        iter     <= '0;
                        state    <= S_CONV;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                S_CONV: begin
                    bcd_sh <= bcd_nx;
                    bin    <= bin << 1;
                    if (iter == IW'(2 * W - 1)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b0;
                        sign  <= res_sign;
                        f_out <= res;
                        bcd   <= bcd_nx;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_core_seq.sv
// Directed and random operations on calc_core_seq (W=4, DEBOUNCE=4) with a result scoreboard,
// latency, debounce, busy-time input changes and mid-operation reset.
module tb_calc_core_seq;
    localparam int W        = 4;
    localparam int DIGITS   = 3;
    localparam int DEBOUNCE = 4;

    logic                clk = 1'b0;
    logic                ar = 1'b0;
    logic                enter = 1'b0;
    logic [1:0]          select = 2'b00;
    logic [W-1:0]        a = '0;
    logic [W-1:0]        b = '0;
    logic                busy, done, err, sign, signA, signB;
    logic [W-1:0]        a_mag, b_mag;
    logic [2*W-1:0]      f_out;
    logic [4*DIGITS-1:0] bcd;
    logic [2:0]          state_dbg;

    int checks = 0;
    int errors = 0;
    logic [21:0] exp_q[$];

    calc_core_seq #(.W(W), .DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE)) dut (
        .clk(clk), .ar(ar), .enter(enter), .select(select), .a(a), .b(b),
        .busy(busy), .done(done), .err(err), .sign(sign), .signA(signA), .signB(signB),
        .a_mag(a_mag), .b_mag(b_mag), .f_out(f_out), .bcd(bcd), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int absv(input logic [3:0] x);
        int xi;
        xi = int'($signed(x));
        return (xi < 0) ? -xi : xi;
    endfunction

    // Packed expectation: {err, sign, f_out[7:0], bcd[11:0]}
    function automatic logic [21:0] model(input logic [1:0] sel, input logic [3:0] av, input logic [3:0] bv);
        int ai, bi, r, m;
        logic e;
        logic [11:0] dg;
        ai = int'($signed(av));
        bi = int'($signed(bv));
        e  = 1'b0;
        r  = 0;
        case (sel)
            2'd0: r = ai + bi;
            2'd1: r = ai - bi;
            2'd2: r = ai * bi;
            default: begin
                if (bi == 0) e = 1'b1;
                else         r = ai / bi;
            end
        endcase
        m  = (r < 0) ? -r : r;
        dg = {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
        return {e, (r < 0), 8'(m), dg};
    endfunction

    function automatic int lat_of(input logic [1:0] sel, input logic [3:0] bv);
        if (sel == 2'd3 && bv == 4'd0) return 2;
        if (sel[1])                    return 1 + W + 2 * W + 1;
        return 1 + 1 + 2 * W + 1;
    endfunction

    // driver: one operation, observed over a fixed window
    task automatic run_op(input logic [1:0] sel, input logic [3:0] av, input logic [3:0] bv,
                          input int hold, input bit repress, input bit chg);
        int first_busy, done_cnt, done_cyc;
        logic [21:0] e, last;
        @(negedge clk);
        select = sel;
        a = av;
        b = bv;
        last = model(sel, av, bv);
        exp_q.push_back(last);
        enter = 1'b1;
        first_busy = -1;
        done_cnt = 0;
        done_cyc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (busy && first_busy < 0) first_busy = cyc;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("extra_done", 64'(done_cnt), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {err, sign, f_out, bcd}, e);
                    chk("busy_at_done", busy, 1'b0);
                end
                chk("operands", {signA, signB, a_mag, b_mag},
                    {av[3], bv[3], 4'(absv(av)), 4'(absv(bv))});
            end
            if (cyc == hold) enter = 1'b0;
            if (repress && cyc == hold + 3) enter = 1'b1;
            if (chg && first_busy >= 0 && cyc == first_busy + 1) begin
                a = ~av;
                b = av;
                select = ~sel;
            end
        end
        chk("start_delay", 64'(first_busy), 64'(DEBOUNCE + 2));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("latency", 64'(done_cyc - first_busy + 1), 64'(lat_of(sel, bv)));
        chk("hold", {err, sign, f_out, bcd}, last);
        while (exp_q.size() > 0) void'(exp_q.pop_front());
        enter = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int fb;
        ar = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, err, sign, signA, signB, a_mag, b_mag, f_out, bcd}, 64'd0);
        chk("reset_state", state_dbg, 3'd0);
        ar = 1'b1;
        repeat (2) @(negedge clk);

        run_op(2'd0, 4'd3, 4'd4, 20, 1'b0, 1'b0);   // 3+4, enter held 20 cycles
        run_op(2'd1, 4'h8, 4'd7, 6, 1'b0, 1'b0);    // -8-7
        run_op(2'd2, 4'h8, 4'h8, 6, 1'b0, 1'b0);    // -8*-8
        run_op(2'd2, 4'hD, 4'd5, 6, 1'b0, 1'b0);    // -3*5
        run_op(2'd3, 4'h9, 4'd2, 6, 1'b0, 1'b0);    // -7/2
        run_op(2'd3, 4'd5, 4'd0, 6, 1'b0, 1'b0);    // divide by zero
        run_op(2'd0, 4'd1, 4'd2, 6, 1'b0, 1'b0);    // clears err
        run_op(2'd0, 4'd2, 4'd5, 6, 1'b1, 1'b0);    // second press while busy
        run_op(2'd2, 4'd7, 4'd3, 6, 1'b0, 1'b1);    // inputs change during EXEC
        run_op(2'd3, 4'h8, 4'hF, 6, 1'b0, 1'b0);    // -8/-1

        // reset mid-CONV
        @(negedge clk);
        select = 2'd0;
        a = 4'd5;
        b = 4'd6;
        enter = 1'b1;
        fb = -1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 6) enter = 1'b0;
            if (busy && fb < 0) fb = cyc;
            if (fb >= 0 && cyc == fb + 5) break;
        end
        chk("abort_reached_busy", 64'(fb >= 0), 64'd1);
        ar = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, err, sign, signA, signB, a_mag, b_mag, f_out, bcd}, 64'd0);
        chk("abort_state", state_dbg, 3'd0);
        repeat (2) @(negedge clk);
        chk("abort_no_done", done, 1'b0);
        ar = 1'b1;
        repeat (2) @(negedge clk);
        run_op(2'd1, 4'd2, 4'd6, 6, 1'b0, 1'b0);    // normal run after abort

        for (int i = 0; i < 6; i++) begin
            run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 6, 1'b0, 1'b0);
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
